// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operation modes, flag bundle and default widths.
package alu_pkg;

    localparam logic ALU_ADD   = 1'b0;
    localparam logic ALU_SUB   = 1'b1;

    localparam int   ALU_WIDTH = 32;
    localparam int   CLA_BLOCK = 8;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry-lookahead slice; b is already inverted for subtraction.
module cla_slice #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb,
    output logic             o_zero
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK:0]   w_c;
    logic             w_acc;
    logic             w_run;

    assign w_p = i_a | i_b;
    assign w_g = i_a & i_b;

    // Every carry is a flat sum of generate terms gated by propagate runs, so
    // no carry waits on its neighbour.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_run  = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < BLOCK; i++) begin
            w_acc = w_g[i];
            w_run = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_run & w_g[j]);
                w_run = w_run & w_p[j];
            end
            w_c[i+1] = w_acc | (w_run & i_cin);
        end
    end

    assign o_sum  = i_a ^ i_b ^ w_c[BLOCK-1:0];
    assign o_cout = w_c[BLOCK];
    assign o_cmsb = w_c[BLOCK-1];
    assign o_zero = ~|o_sum;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one lookahead slice per stage, registered carry between
// stages, skewed operands and deskewed sums, with a single global stall enable.
module pipelined_cla_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NS = WIDTH / BLOCK;

    logic             w_en;
    logic [NS:0]      r_vld_pipe;
    logic [WIDTH-1:0] r_sum;
    alu_flags_t       r_flags;

    assign w_en      = ~r_vld_pipe[NS] | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld_pipe[NS];
    assign out_sum   = r_sum;
    assign out_cout  = r_flags.cout;
    assign out_ovf   = r_flags.ovf;
    assign out_zero  = r_flags.zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_vld_pipe <= '0;
        else if (w_en) r_vld_pipe <= {r_vld_pipe[NS-1:0], in_valid};
    end

    for (genvar k = 0; k < NS; k++) begin : g_stg
        localparam int OW = WIDTH - k * BLOCK;

        // Finished sum slices sit below bit k*BLOCK, unconsumed operand A above it.
        logic [WIDTH-1:0] r_as;
        logic [OW-1:0]    r_b;
        logic             r_c;
        logic             r_z;
        logic [BLOCK-1:0] w_sum;
        logic             w_cout;
        logic             w_cmsb;
        logic             w_zero;
        logic [WIDTH-1:0] w_as_nxt;

        cla_slice #(.BLOCK(BLOCK)) u_slice (
            .i_a    (r_as[k*BLOCK +: BLOCK]),
            .i_b    (r_b[BLOCK-1:0]),
            .i_cin  (r_c),
            .o_sum  (w_sum),
            .o_cout (w_cout),
            .o_cmsb (w_cmsb),
            .o_zero (w_zero)
        );

        always_comb begin
            w_as_nxt                   = r_as;
            w_as_nxt[k*BLOCK +: BLOCK] = w_sum;
        end

        if (k == 0) begin : g_head
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_as <= '0;
                    r_b  <= '0;
                    r_c  <= 1'b0;
                    r_z  <= 1'b0;
                end else if (w_en) begin
                    r_as <= in_a;
                    r_b  <= (in_sub == ALU_SUB) ? ~in_b : in_b;
                    r_c  <= (in_sub == ALU_SUB) | in_cin;
                    r_z  <= 1'b1;
                end
            end
        end else begin : g_body
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_as <= '0;
                    r_b  <= '0;
                    r_c  <= 1'b0;
                    r_z  <= 1'b0;
                end else if (w_en) begin
                    r_as <= g_stg[k-1].w_as_nxt;
                    r_b  <= g_stg[k-1].r_b[OW+BLOCK-1:BLOCK];
                    r_c  <= g_stg[k-1].w_cout;
                    r_z  <= g_stg[k-1].r_z & g_stg[k-1].w_zero;
                end
            end
        end

        // Only the top slice's carry-into-MSB feeds the overflow flag.
        if (k < NS - 1) begin : g_mid
            logic w_unused_cmsb;
            assign w_unused_cmsb = w_cmsb;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum   <= '0;
            r_flags <= '0;
        end else if (w_en) begin
            r_sum        <= g_stg[NS-1].w_as_nxt;
            r_flags.cout <= g_stg[NS-1].w_cout;
            r_flags.ovf  <= g_stg[NS-1].w_cmsb ^ g_stg[NS-1].w_cout;
            r_flags.zero <= g_stg[NS-1].r_z & g_stg[NS-1].w_zero;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and streaming checks of the pipelined adder at 32/8 and 16/4 geometries.
module tb_pipelined_cla_adder;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        iv, ir, isub, icin, ov, ordy, oc, oo, oz;
    logic [31:0] ia, ib, os;
    logic        iv_h, ir_h, isub_h, icin_h, ov_h, ordy_h, oc_h, oo_h, oz_h;
    logic [15:0] ia_h, ib_h, os_h;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv), .in_ready(ir),
        .in_a(ia), .in_b(ib), .in_sub(isub), .in_cin(icin),
        .out_valid(ov), .out_ready(ordy), .out_sum(os),
        .out_cout(oc), .out_ovf(oo), .out_zero(oz)
    );

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv_h), .in_ready(ir_h),
        .in_a(ia_h), .in_b(ib_h), .in_sub(isub_h), .in_cin(icin_h),
        .out_valid(ov_h), .out_ready(ordy_h), .out_sum(os_h),
        .out_cout(oc_h), .out_ovf(oo_h), .out_zero(oz_h)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[8];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Result packed as {sum, cout, ovf, zero}.
    function automatic logic [34:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cin);
        logic [31:0] bb;
        logic [32:0] t;
        logic        v;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, sub ? 1'b1 : cin};
        v  = (a[31] == bb[31]) && (t[31] != a[31]);
        return {t[31:0], t[32], v, t[31:0] == 32'd0};
    endfunction

    function automatic logic [18:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        logic [15:0] bb;
        logic [16:0] t;
        logic        v;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {16'd0, sub ? 1'b1 : cin};
        v  = (a[15] == bb[15]) && (t[15] != a[15]);
        return {t[15:0], t[16], v, t[15:0] == 16'd0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [34:0] expq[$];
        logic [18:0] expq_h[$];
        logic [34:0] e;
        logic [18:0] eh;
        int          lat, issued, got, stall, hits;
        logic        acc;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0001, 32'h0000_0001, ALU_ADD, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, ALU_SUB, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, ALU_SUB, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0007, 32'h0000_0007, ALU_SUB, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, ALU_ADD, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h8000_0000, ALU_SUB, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

        iv = 0; ia = '0; ib = '0; isub = 0; icin = 0; ordy = 1;
        iv_h = 0; ia_h = '0; ib_h = '0; isub_h = 0; icin_h = 0; ordy_h = 1;

        #2;
        chk("reset_out_valid", ov, 0);
        chk("reset_out_sum", os, 0);
        chk("reset_out_cout", oc, 0);
        chk("reset_out_ovf", oo, 0);
        chk("reset_out_zero", oz, 0);
        step();
        step();
        reset_n = 1;
        #1;
        chk("reset_in_ready", ir, 1);

        // Directed single ops: latency and flags.
        for (int i = 0; i < 8; i++) begin
            ia = vecs[i].a; ib = vecs[i].b; isub = vecs[i].sub; icin = vecs[i].cin;
            iv = 1; ordy = 1;
            step();
            iv = 0;
            lat = 0;
            while (!ov && lat < 20) begin
                step();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_sum", i), os, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), oc, vecs[i].cout);
            chk($sformatf("vec%0d_ovf", i), oo, vecs[i].ovf);
            chk($sformatf("vec%0d_zero", i), oz, vecs[i].zero);
        end
        step();

        // Eight back-to-back ops with a three-cycle consumer stall after five results.
        issued = 0; got = 0; stall = 0;
        ia = $urandom; ib = $urandom; isub = 1'($urandom_range(0, 1)); icin = 1'($urandom_range(0, 1));
        iv = 1;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            ordy = (got >= 5 && stall < 3) ? 1'b0 : 1'b1;
            if (!ordy) stall++;
            #1;
            if (!ordy) chk("stall_in_ready", ir, 0);
            if (ov) begin
                if (expq.size() == 0) begin
                    chk("b2b_spurious_valid", ov, 0);
                end else begin
                    chk($sformatf("b2b_result%0d", got), {os, oc, oo, oz}, expq[0]);
                    if (ordy) begin
                        void'(expq.pop_front());
                        got++;
                    end
                end
            end
            acc = iv && ir;
            if (acc) begin
                expq.push_back(ref32(ia, ib, isub, icin));
                issued++;
            end
            @(posedge clock);
            #1;
            if (acc) begin
                if (issued < 8) begin
                    ia = $urandom; ib = $urandom;
                    isub = 1'($urandom_range(0, 1)); icin = 1'($urandom_range(0, 1));
                end else begin
                    iv = 0;
                end
            end
        end
        chk("b2b_count", got, 8);
        chk("b2b_issued", issued, 8);
        chk("b2b_queue_empty", expq.size(), 0);
        chk("b2b_stall_cycles", stall, 3);
        ordy = 1;
        step();
        chk("b2b_no_duplicate", ov, 0);

        // Reset while three ops are in flight and one result is held at the output.
        ordy = 0;
        iv = 1; isub = ALU_ADD; icin = 0;
        ia = 32'hF000_0000; ib = 32'h2000_0000; step();
        ia = 32'h1234_5678; ib = 32'h1111_1111; step();
        ia = 32'h0000_00FF; ib = 32'h0000_0001; step();
        iv = 0;
        step();
        step();
        chk("prerst_out_valid", ov, 1);
        chk("prerst_out_sum", os, 32'h1000_0000);
        chk("prerst_out_cout", oc, 1);
        #1;
        reset_n = 0;
        #1;
        chk("midrst_out_valid", ov, 0);
        chk("midrst_out_sum", os, 0);
        chk("midrst_out_cout", oc, 0);
        step();
        reset_n = 1;
        ordy = 1;
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ov) hits++;
        end
        chk("postrst_no_stale_result", hits, 0);
        chk("postrst_in_ready", ir, 1);

        // 16/4 geometry: wrap-around latency check.
        ia_h = 16'hFFFF; ib_h = 16'h0001; isub_h = ALU_ADD; icin_h = 0;
        iv_h = 1; ordy_h = 1;
        step();
        iv_h = 0;
        lat = 0;
        while (!ov_h && lat < 20) begin
            step();
            lat++;
        end
        chk("w16_latency", lat, 4);
        chk("w16_sum", os_h, 16'h0000);
        chk("w16_cout", oc_h, 1);
        chk("w16_ovf", oo_h, 0);
        chk("w16_zero", oz_h, 1);
        step();

        // 16/4 geometry: random stream with random bubbles and backpressure.
        issued = 0; got = 0;
        iv_h = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            ordy_h = ($urandom_range(0, 3) != 0);
            #1;
            if (ov_h) begin
                if (expq_h.size() == 0) begin
                    chk("w16_spurious_valid", ov_h, 0);
                end else begin
                    chk($sformatf("w16_result%0d", got), {os_h, oc_h, oo_h, oz_h}, expq_h[0]);
                    if (ordy_h) begin
                        void'(expq_h.pop_front());
                        got++;
                    end
                end
            end
            acc = iv_h && ir_h;
            if (acc) begin
                expq_h.push_back(ref16(ia_h, ib_h, isub_h, icin_h));
                issued++;
            end
            @(posedge clock);
            #1;
            if (acc || !iv_h) begin
                if (issued < 1000) begin
                    iv_h = ($urandom_range(0, 3) != 0);
                    ia_h = 16'($urandom); ib_h = 16'($urandom);
                    isub_h = 1'($urandom_range(0, 1)); icin_h = 1'($urandom_range(0, 1));
                end else begin
                    iv_h = 0;
                end
            end
        end
        chk("w16_stream_count", got, 1000);
        chk("w16_stream_queue_empty", expq_h.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
